// File: rtl/d8_imem_arb.sv
// rtl/d8_imem_arb.sv - dumb8 imem arbiter, fetch vs debug port; stats ports via D8_IMEM_ARB_STATS_EN
module d8_imem_arb #(
    parameter int AW     = 8,
    parameter int DW     = 16,
    parameter int STARVE = 4
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic [DW-1:0] f_data,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    input  logic          d_halt,
    output logic          cpu_stall,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
`ifdef D8_IMEM_ARB_STATS_EN
    ,
    output logic [15:0]   st_dbg,
    output logic [15:0]   st_wait
`endif
);

    localparam logic [3:0] STARVE_CNT = 4'(STARVE);

    logic       grant_f;
    logic       grant_d;
    logic       starve_hit;
    logic       busy_f;
    logic       busy_d;
    logic       we_q;
    logic [3:0] starve_cnt;

    // Grant: fetch by default, debug when fetch is idle, halted, or debug has waited long enough
    always_comb begin
        starve_hit = (starve_cnt == STARVE_CNT);
        grant_d    = d_req & (d_halt | ~f_req | starve_hit);
        grant_f    = f_req & ~d_halt & ~grant_d;
    end

    // Memory port mux: winner drives the port, idle port is all zeros
    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (grant_d) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (grant_f) begin
            m_en    = 1'b1;
            m_addr  = f_addr;
        end
    end

    // In-flight tracking: a grant in cycle N becomes an ack in N+1
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy_f <= 1'b0;
            busy_d <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            busy_f <= grant_f;
            busy_d <= grant_d;
            we_q   <= grant_d & d_we;
        end
    end

    // Starvation counter: cycles debug has been waiting behind fetch, saturating
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            starve_cnt <= 4'd0;
        end else if (grant_d || !d_req) begin
            starve_cnt <= 4'd0;
        end else if (!starve_hit) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign f_ack     = busy_f;
    assign d_ack     = busy_d;
    assign f_data    = busy_f ? m_rdata : '0;
    assign d_rdata   = (busy_d && !we_q) ? m_rdata : '0;
    assign cpu_stall = d_halt | (f_req & ~grant_f);

`ifdef D8_IMEM_ARB_STATS_EN
    // Statistics: debug grants and cycles a debug request spent waiting, both saturating
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            st_dbg  <= 16'h0000;
            st_wait <= 16'h0000;
        end else begin
            if (grant_d && st_dbg != 16'hffff) begin
                st_dbg <= st_dbg + 16'h0001;
            end
            if (d_req && !grant_d && st_wait != 16'hffff) begin
                st_wait <= st_wait + 16'h0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_d8_imem_arb.sv
// tb/tb_d8_imem_arb.sv - self-checking bench for d8_imem_arb with reference model
module tb_d8_imem_arb;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          f_req, d_req, d_we, d_halt;
    logic [AW-1:0] f_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          f_ack, d_ack, cpu_stall, m_en, m_we;
    logic [DW-1:0] f_data, d_rdata, m_wdata, m_rdata;
    logic [AW-1:0] m_addr;
`ifdef D8_IMEM_ARB_STATS_EN
    logic [15:0]   st_dbg, st_wait;
`endif

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];

    int checks = 0;
    int fails  = 0;

    int            lost;
    bit            pend_f, pend_d, e_gd, e_gf;
    logic [DW-1:0] exp_fq, exp_dq;
    int            mst_dbg, mst_wait;

    always #5 clk = ~clk;

    d8_imem_arb #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_data(f_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_halt(d_halt), .cpu_stall(cpu_stall),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef D8_IMEM_ARB_STATS_EN
        , .st_dbg(st_dbg), .st_wait(st_wait)
`endif
    );

    // Sync-read, write-first instruction memory
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) begin
                mem[m_addr] <= m_wdata;
                m_rdata     <= m_wdata;
            end else begin
                m_rdata <= mem[m_addr];
            end
        end
    end

    task automatic model_eval();
        e_gd = d_req && (d_halt || !f_req || lost >= STARVE);
        e_gf = f_req && !d_halt && !e_gd;
    endtask

    task automatic model_commit();
        if (e_gd) begin
            if (d_we) begin
                ref_mem[d_addr] = d_wdata;
                exp_dq = '0;
            end else begin
                exp_dq = ref_mem[d_addr];
            end
        end
        if (e_gf) exp_fq = ref_mem[f_addr];
        if (!rst_n) begin
            pend_f = 0; pend_d = 0; lost = 0; mst_dbg = 0; mst_wait = 0;
        end else begin
            pend_f = e_gf;
            pend_d = e_gd;
            if (e_gd && mst_dbg < 65535) mst_dbg++;
            if (d_req && !e_gd && mst_wait < 65535) mst_wait++;
            if (e_gd || !d_req) lost = 0;
            else if (lost < STARVE) lost++;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        pend_f = 0; pend_d = 0; lost = 0; mst_dbg = 0; mst_wait = 0;
    endtask

    task automatic test_reset();
        enter_reset();
        {f_req, d_req, d_we, d_halt} = '0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        sample();
        checks++;
        if (f_ack !== 1'b0 || d_ack !== 1'b0 || f_data !== '0 || d_rdata !== '0) begin
            fails++;
            $display("FAIL reset_outputs f_ack=%b d_ack=%b f_data=%h d_rdata=%h want 0/0/0/0",
                     f_ack, d_ack, f_data, d_rdata);
        end
        checks++;
        if (m_en !== 1'b0 || cpu_stall !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle m_en=%b cpu_stall=%b want 0/0", m_en, cpu_stall);
        end
        f_req = 1'b1; f_addr = 8'h03;
        #1;
        checks++;
        if (m_en !== 1'b1 || m_addr !== 8'h03 || cpu_stall !== 1'b0 || f_ack !== 1'b0) begin
            fails++;
            $display("FAIL reset_comb_grant m_en=%b m_addr=%h stall=%b f_ack=%b want 1/03/0/0",
                     m_en, m_addr, cpu_stall, f_ack);
        end
        f_req = 1'b0;
        model_eval();
        advance();
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_stream();
        for (int i = 0; i < 5; i++) begin
            f_req  = (i < 4);
            f_addr = 8'(i);
            sample();
            if (i < 4) begin
                checks++;
                if (m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== 8'(i)) begin
                    fails++;
                    $display("FAIL fetch_grant[%0d] m_en=%b m_we=%b m_addr=%h want 1/0/%h",
                             i, m_en, m_we, m_addr, 8'(i));
                end
            end
            checks++;
            if (f_ack !== (i > 0) || f_data !== ((i > 0) ? 16'h0100 + 16'(i - 1) : 16'h0000)) begin
                fails++;
                $display("FAIL fetch_data[%0d] f_ack=%b f_data=%h want %b/%h", i, f_ack, f_data,
                         (i > 0), ((i > 0) ? 16'h0100 + 16'(i - 1) : 16'h0000));
            end
            advance();
        end
    endtask

    task automatic test_debug_write();
        f_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 16'hbeef;
        sample();
        checks++;
        if (m_en !== 1'b1 || m_we !== 1'b1 || m_addr !== 8'h10 || m_wdata !== 16'hbeef) begin
            fails++;
            $display("FAIL dbg_write_port m_en=%b m_we=%b m_addr=%h m_wdata=%h want 1/1/10/beef",
                     m_en, m_we, m_addr, m_wdata);
        end
        advance();
        d_req = 1'b0; d_we = 1'b0; f_req = 1'b1; f_addr = 8'h10;
        sample();
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 16'h0000 || m_we !== 1'b0 || m_addr !== 8'h10) begin
            fails++;
            $display("FAIL dbg_write_ack d_ack=%b d_rdata=%h m_we=%b m_addr=%h want 1/0000/0/10",
                     d_ack, d_rdata, m_we, m_addr);
        end
        advance();
        f_req = 1'b0;
        sample();
        checks++;
        if (f_ack !== 1'b1 || f_data !== 16'hbeef || d_ack !== 1'b0) begin
            fails++;
            $display("FAIL fetch_after_write f_ack=%b f_data=%h d_ack=%b want 1/beef/0",
                     f_ack, f_data, d_ack);
        end
        advance();
    endtask

    task automatic test_starvation();
        bit prev_d;
        enter_reset();
        advance();
        rst_n = 1'b1;
        prev_d = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 8'h02; f_req = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bit want_d;
            want_d = (c % 5 == 4);
            f_addr = 8'($urandom_range(0, 15));
            sample();
            checks++;
            if (m_en !== 1'b1 || m_addr !== (want_d ? d_addr : f_addr) || cpu_stall !== want_d) begin
                fails++;
                $display("FAIL starve_grant[%0d] m_addr=%h stall=%b want %h/%b", c, m_addr,
                         cpu_stall, (want_d ? d_addr : f_addr), want_d);
            end
            if (c > 0) begin
                checks++;
                if (d_ack !== prev_d || f_ack !== !prev_d) begin
                    fails++;
                    $display("FAIL starve_ack[%0d] d_ack=%b f_ack=%b want %b/%b", c, d_ack, f_ack,
                             prev_d, !prev_d);
                end
            end
            prev_d = want_d;
            advance();
        end
        f_req = 1'b0; d_req = 1'b0;
        sample();
`ifdef D8_IMEM_ARB_STATS_EN
        checks++;
        if (st_dbg !== 16'd2 || st_wait !== 16'd8) begin
            fails++;
            $display("FAIL stats_starve st_dbg=%0d st_wait=%0d want 2/8", st_dbg, st_wait);
        end
`endif
        checks++;
        if (d_ack !== 1'b1 || d_rdata !== 16'h0102) begin
            fails++;
            $display("FAIL starve_dbg_read d_ack=%b d_rdata=%h want 1/0102", d_ack, d_rdata);
        end
        advance();
    endtask

    task automatic test_halt();
        f_req = 1'b1; f_addr = 8'h06; d_halt = 1'b0;
        sample();
        advance();
        d_halt = 1'b1; f_req = 1'b0;
        sample();
        checks++;
        if (f_ack !== 1'b1 || f_data !== ref_mem[6] || cpu_stall !== 1'b1 || m_en !== 1'b0) begin
            fails++;
            $display("FAIL halt_inflight f_ack=%b f_data=%h stall=%b m_en=%b want 1/%h/1/0",
                     f_ack, f_data, cpu_stall, m_en, ref_mem[6]);
        end
        advance();
        f_req = 1'b1; f_addr = 8'h05; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h00;
        sample();
        checks++;
        if (cpu_stall !== 1'b1 || m_en !== 1'b1 || m_we !== 1'b0 || m_addr !== 8'h00) begin
            fails++;
            $display("FAIL halt_dbg_grant stall=%b m_en=%b m_we=%b m_addr=%h want 1/1/0/00",
                     cpu_stall, m_en, m_we, m_addr);
        end
        advance();
        d_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            sample();
            checks++;
            if (f_ack !== 1'b0 || m_en !== 1'b0 || cpu_stall !== 1'b1 ||
                d_ack !== (c == 0) || d_rdata !== ((c == 0) ? 16'h0100 : 16'h0000)) begin
                fails++;
                $display("FAIL halt_hold[%0d] f_ack=%b m_en=%b stall=%b d_ack=%b d_rdata=%h", c,
                         f_ack, m_en, cpu_stall, d_ack, d_rdata);
            end
            advance();
        end
        d_halt = 1'b0;
        sample();
        checks++;
        if (cpu_stall !== 1'b0 || m_en !== 1'b1 || m_addr !== 8'h05) begin
            fails++;
            $display("FAIL halt_release stall=%b m_en=%b m_addr=%h want 0/1/05", cpu_stall, m_en,
                     m_addr);
        end
        advance();
        f_req = 1'b0;
        sample();
        checks++;
        if (f_ack !== 1'b1 || f_data !== ref_mem[5]) begin
            fails++;
            $display("FAIL halt_resume_data f_ack=%b f_data=%h want 1/%h", f_ack, f_data,
                     ref_mem[5]);
        end
        advance();
    endtask

    task automatic test_reset_midflight();
        f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h07; f_addr = 8'h01;
        for (int c = 0; c < 2; c++) begin
            sample();
            advance();
        end
        enter_reset();
        f_req = 1'b0; d_req = 1'b0;
        sample();
        checks++;
        if (f_ack !== 1'b0 || f_data !== '0 || d_ack !== 1'b0 || d_rdata !== '0) begin
            fails++;
            $display("FAIL reset_drop f_ack=%b f_data=%h d_ack=%b d_rdata=%h want 0/0/0/0",
                     f_ack, f_data, d_ack, d_rdata);
        end
        advance();
        rst_n = 1'b1;
        f_req = 1'b1; d_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            f_addr = 8'(c);
            sample();
            checks++;
            if (m_addr !== ((c == 4) ? 8'h07 : 8'(c)) || f_ack !== (c >= 1 && c <= 4)) begin
                fails++;
                $display("FAIL reset_restart[%0d] m_addr=%h f_ack=%b want %h/%b", c, m_addr, f_ack,
                         ((c == 4) ? 8'h07 : 8'(c)), (c >= 1 && c <= 4));
            end
            advance();
        end
        f_req = 1'b0; d_req = 1'b0;
        sample();
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] x_addr;
            logic [DW-1:0] x_wdata;
            if (!(f_req && !e_gf)) begin
                f_req  = ($urandom_range(0, 3) != 0);
                f_addr = 8'($urandom_range(0, 15));
            end
            if (!(d_req && !e_gd)) begin
                d_req   = ($urandom_range(0, 2) == 0);
                d_we    = $urandom_range(0, 1);
                d_addr  = 8'($urandom_range(0, 15));
                d_wdata = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) d_halt = ~d_halt;
            sample();
            x_addr  = e_gd ? d_addr : (e_gf ? f_addr : 8'h00);
            x_wdata = e_gd ? d_wdata : 16'h0000;
            checks++;
            if (m_en !== (e_gd || e_gf) || m_we !== (e_gd && d_we) || m_addr !== x_addr ||
                m_wdata !== x_wdata || cpu_stall !== (d_halt || (f_req && !e_gf))) begin
                fails++;
                $display("FAIL rand_port[%0d] en=%b we=%b addr=%h wd=%h stall=%b want %b/%b/%h/%h/%b",
                         n, m_en, m_we, m_addr, m_wdata, cpu_stall, (e_gd || e_gf), (e_gd && d_we),
                         x_addr, x_wdata, (d_halt || (f_req && !e_gf)));
            end
            checks++;
            if (f_ack !== pend_f || f_data !== (pend_f ? exp_fq : 16'h0000) ||
                d_ack !== pend_d || d_rdata !== (pend_d ? exp_dq : 16'h0000)) begin
                fails++;
                $display("FAIL rand_ack[%0d] f=%b/%h d=%b/%h want %b/%h %b/%h", n, f_ack, f_data,
                         d_ack, d_rdata, pend_f, (pend_f ? exp_fq : 16'h0000), pend_d,
                         (pend_d ? exp_dq : 16'h0000));
            end
            advance();
        end
`ifdef D8_IMEM_ARB_STATS_EN
        sample();
        checks++;
        if (st_dbg !== 16'(mst_dbg) || st_wait !== 16'(mst_wait)) begin
            fails++;
            $display("FAIL rand_stats st_dbg=%0d st_wait=%0d want %0d/%0d", st_dbg, st_wait,
                     mst_dbg, mst_wait);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = (i < 16) ? 16'h0100 + 16'(i) : 16'($urandom);
            ref_mem[i] = mem[i];
        end
        m_rdata = '0;
        lost = 0; pend_f = 0; pend_d = 0; e_gd = 0; e_gf = 0;
        exp_fq = '0; exp_dq = '0; mst_dbg = 0; mst_wait = 0;
        test_reset();
        test_fetch_stream();
        test_debug_write();
        test_starvation();
        test_halt();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
